// File: rtl/fptd_frame_loader_if.sv
// Serial LLR beat stream feeding the FPTD frame loader.
interface fptd_beat_if #(
    parameter int unsigned N = 4
);
    logic                In_Valid;
    logic                In_Ready;
    logic signed [N-1:0] In_Sys;
    logic signed [N-1:0] In_Par_U;
    logic signed [N-1:0] In_Par_L;
    logic                In_Bit;

    modport master (
        output In_Valid,
        output In_Sys,
        output In_Par_U,
        output In_Par_L,
        output In_Bit,
        input  In_Ready
    );

    modport slave (
        input  In_Valid,
        input  In_Sys,
        input  In_Par_U,
        input  In_Par_L,
        input  In_Bit,
        output In_Ready
    );
endinterface

// File: rtl/fptd_frame_loader.sv
// Frame loader for the FPTD turbo-decoder core: assembles serial LLR beats
// into the core's parallel frame vectors, launches a decode and keeps BER
// statistics from the per-frame error counts the core reports back.
module fptd_frame_loader #(
    parameter int unsigned FL = 104,
    parameter int unsigned N  = 4,
    parameter int unsigned EW = 24,
    parameter int unsigned CW = 16
) (
    input  logic                 Clock,
    input  logic                 nReset,
    fptd_beat_if.slave           beat,
    input  logic                 Clear_Stats,
    output logic                 Start,
    input  logic                 Ready,
    input  logic                 Valid_Data,
    input  logic [6:0]           Errors,
    output logic [FL-1:0]        b1_ideal,
    output logic [FL*N-1:0]      bua3,
    output logic [(FL+3)*N-1:0]  bua2,
    output logic [3*N-1:0]       but1,
    output logic [(FL+3)*N-1:0]  bla2,
    output logic [3*N-1:0]       blt1,
    output logic                 Frame_Done,
    output logic [6:0]           Last_Errors,
    output logic [EW-1:0]        Total_Errors,
    output logic [CW-1:0]        Frame_Count
);
    localparam int unsigned BEATS = FL + 6;
    localparam int unsigned KW    = $clog2(BEATS);
    localparam int unsigned LAST  = BEATS - 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ARM,
        S_DECODE
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic          vd_q;
    logic          accept_c;
    logic          capture_c;
    logic [EW:0]   sum_c;

    // Beats are only taken while loading; ready is a pure decode of the state register.
    assign beat.In_Ready = (state == S_LOAD);
    assign accept_c      = beat.In_Valid && (state == S_LOAD);
    assign capture_c     = (state == S_DECODE) && Valid_Data && !vd_q;
    assign sum_c         = {1'b0, Total_Errors} + (EW+1)'(Errors);

    // Frame FSM: beat routing into the frame buffers, start request, result capture.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= S_LOAD;
            k           <= '0;
            vd_q        <= 1'b0;
            Start       <= 1'b0;
            Frame_Done  <= 1'b0;
            Last_Errors <= '0;
            b1_ideal    <= '0;
            bua3        <= '0;
            bua2        <= '0;
            but1        <= '0;
            bla2        <= '0;
            blt1        <= '0;
        end else begin
            Start      <= 1'b0;
            Frame_Done <= 1'b0;
            vd_q       <= Valid_Data;
            case (state)
                S_LOAD: begin
                    if (accept_c) begin
                        for (int i = 0; i < int'(FL); i++) begin
                            if (k == KW'(i)) begin
                                b1_ideal[i]      <= beat.In_Bit;
                                bua3[i*N +: N]   <= beat.In_Sys;
                                bua2[i*N +: N]   <= beat.In_Par_U;
                                bla2[i*N +: N]   <= beat.In_Par_L;
                            end
                        end
                        for (int j = 0; j < 3; j++) begin
                            if (k == KW'(int'(FL) + j)) begin
                                but1[j*N +: N]                <= beat.In_Sys;
                                bua2[(int'(FL) + j)*N +: N]   <= beat.In_Par_U;
                            end
                            if (k == KW'(int'(FL) + 3 + j)) begin
                                blt1[j*N +: N]                <= beat.In_Sys;
                                bla2[(int'(FL) + j)*N +: N]   <= beat.In_Par_L;
                            end
                        end
                        if (k == KW'(LAST)) begin
                            k     <= '0;
                            state <= S_ARM;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (Ready) begin
                        Start <= 1'b1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (capture_c) begin
                        Last_Errors <= Errors;
                        Frame_Done  <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Running statistics: saturating error total and wrapping frame count.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Total_Errors <= '0;
            Frame_Count  <= '0;
        end else if (Clear_Stats) begin
            Total_Errors <= capture_c ? EW'(Errors) : '0;
            Frame_Count  <= capture_c ? CW'(1) : '0;
        end else if (capture_c) begin
            Total_Errors <= sum_c[EW] ? '1 : sum_c[EW-1:0];
            Frame_Count  <= Frame_Count + CW'(1);
        end
    end
endmodule

// File: tb/tb_fptd_frame_loader.sv
// Randomized scoreboard bench for fptd_frame_loader.
module tb_fptd_frame_loader;
    localparam int FL = 104;
    localparam int N  = 4;
    localparam int EW = 8;   // narrow total so saturation is reachable in a short run
    localparam int CW = 16;
    localparam int SAT = (1 << EW) - 1;

    typedef struct packed {
        logic [FL-1:0]        ideal;
        logic [FL*N-1:0]      ua3;
        logic [(FL+3)*N-1:0]  ua2;
        logic [3*N-1:0]       ut1;
        logic [(FL+3)*N-1:0]  la2;
        logic [3*N-1:0]       lt1;
    } frame_t;

    typedef struct packed {
        logic [6:0]    last;
        logic [EW-1:0] total;
        logic [CW-1:0] count;
    } stats_t;

    logic                Clock;
    logic                nReset;
    logic                Clear_Stats;
    logic                Start;
    logic                Ready;
    logic                Valid_Data;
    logic [6:0]          Errors;
    logic [FL-1:0]       b1_ideal;
    logic [FL*N-1:0]     bua3;
    logic [(FL+3)*N-1:0] bua2;
    logic [3*N-1:0]      but1;
    logic [(FL+3)*N-1:0] bla2;
    logic [3*N-1:0]      blt1;
    logic                Frame_Done;
    logic [6:0]          Last_Errors;
    logic [EW-1:0]       Total_Errors;
    logic [CW-1:0]       Frame_Count;

    fptd_beat_if #(.N(N)) beat ();

    fptd_frame_loader #(.FL(FL), .N(N), .EW(EW), .CW(CW)) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .beat         (beat),
        .Clear_Stats  (Clear_Stats),
        .Start        (Start),
        .Ready        (Ready),
        .Valid_Data   (Valid_Data),
        .Errors       (Errors),
        .b1_ideal     (b1_ideal),
        .bua3         (bua3),
        .bua2         (bua2),
        .but1         (but1),
        .bla2         (bla2),
        .blt1         (blt1),
        .Frame_Done   (Frame_Done),
        .Last_Errors  (Last_Errors),
        .Total_Errors (Total_Errors),
        .Frame_Count  (Frame_Count)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_frames_pushed = 0;

    // Reference model: frame contents as element arrays, statistics as plain integers.
    logic [N-1:0] m_ua3 [FL];
    logic [N-1:0] m_ua2 [FL+3];
    logic [N-1:0] m_la2 [FL+3];
    logic [N-1:0] m_ut1 [3];
    logic [N-1:0] m_lt1 [3];
    logic         m_ideal [FL];
    int           m_total, m_count, m_last;

    frame_t exp_frames [$];
    stats_t exp_stats  [$];

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FL; i++) begin m_ua3[i] = '0; m_ideal[i] = 1'b0; end
        for (int i = 0; i < FL + 3; i++) begin m_ua2[i] = '0; m_la2[i] = '0; end
        for (int i = 0; i < 3; i++) begin m_ut1[i] = '0; m_lt1[i] = '0; end
        m_total = 0; m_count = 0; m_last = 0;
    endtask

    task automatic model_beat(input int k, input logic [N-1:0] s, input logic [N-1:0] pu,
                              input logic [N-1:0] pl, input logic b);
        if (k < FL) begin
            m_ua3[k] = s; m_ua2[k] = pu; m_la2[k] = pl; m_ideal[k] = b;
        end else if (k < FL + 3) begin
            m_ut1[k-FL] = s; m_ua2[k] = pu;
        end else begin
            m_lt1[k-FL-3] = s; m_la2[k-3] = pl;
        end
    endtask

    function automatic frame_t model_pack();
        frame_t f;
        for (int i = 0; i < FL; i++) begin
            f.ideal[i] = m_ideal[i];
            f.ua3[i*N +: N] = m_ua3[i];
        end
        for (int i = 0; i < FL + 3; i++) begin
            f.ua2[i*N +: N] = m_ua2[i];
            f.la2[i*N +: N] = m_la2[i];
        end
        for (int i = 0; i < 3; i++) begin
            f.ut1[i*N +: N] = m_ut1[i];
            f.lt1[i*N +: N] = m_lt1[i];
        end
        return f;
    endfunction

    task automatic model_capture(input int e, input bit clr);
        stats_t s;
        m_last = e;
        if (clr) begin
            m_total = e;
            m_count = 1;
        end else begin
            m_total = (m_total + e > SAT) ? SAT : m_total + e;
            m_count = (m_count + 1) % (1 << CW);
        end
        s.last = 7'(m_last); s.total = EW'(m_total); s.count = CW'(m_count);
        exp_stats.push_back(s);
    endtask

    task automatic drive_idle();
        beat.In_Valid = 1'b0;
        beat.In_Sys = '0; beat.In_Par_U = '0; beat.In_Par_L = '0; beat.In_Bit = 1'b0;
        Ready = 1'b0; Valid_Data = 1'b0; Clear_Stats = 1'b0; Errors = '0;
    endtask

    // Asynchronous reset with random inputs; every output must read zero.
    task automatic apply_reset();
        #2;
        nReset = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            beat.In_Valid = 1'($urandom); beat.In_Sys = N'($urandom);
            beat.In_Par_U = N'($urandom); beat.In_Par_L = N'($urandom);
            beat.In_Bit = 1'($urandom); Ready = 1'($urandom);
            Valid_Data = 1'($urandom); Clear_Stats = 1'($urandom); Errors = 7'($urandom);
            @(negedge Clock);
        end
        chk("rst_start", Start, 0);
        chk("rst_frame_done", Frame_Done, 0);
        chk("rst_stats", {Last_Errors, Total_Errors, Frame_Count}, 0);
        chk("rst_buffers", |{b1_ideal, bua3, bua2, but1, bla2, blt1}, 0);
        drive_idle();
        nReset = 1'b1;
        @(negedge Clock);
        chk("rst_in_ready", beat.In_Ready, 1);
        chk("rst_start_after", Start, 0);
    endtask

    // mode 0: fixed index pattern, mode 1: random. gap 0: none, 1: alternate, 2: random.
    task automatic send_beats(input int nb, input int mode, input int gap);
        logic [31:0] kk;
        logic [N-1:0] s, pu, pl;
        logic b;
        for (int k = 0; k < nb; k++) begin
            int idle;
            idle = (gap == 1 && k > 0) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < idle; g++) begin
                @(negedge Clock);
                beat.In_Valid = 1'b0;
                beat.In_Sys = N'($urandom); beat.In_Par_U = N'($urandom);
                beat.In_Par_L = N'($urandom); beat.In_Bit = 1'($urandom);
            end
            @(negedge Clock);
            if (k == 0) chk("in_ready_frame_start", beat.In_Ready, 1);
            kk = 32'(k);
            if (mode == 0) begin
                s = kk[3:0]; pu = ~kk[3:0]; pl = kk[3:0] ^ 4'h5; b = kk[0];
            end else begin
                s = N'($urandom); pu = N'($urandom); pl = N'($urandom); b = 1'($urandom);
            end
            beat.In_Valid = 1'b1;
            beat.In_Sys = s; beat.In_Par_U = pu; beat.In_Par_L = pl; beat.In_Bit = b;
            model_beat(k, s, pu, pl, b);
            @(posedge Clock);
        end
        if (nb == FL + 6) begin
            exp_frames.push_back(model_pack());
            n_frames_pushed++;
        end
        @(negedge Clock);
        beat.In_Valid = 1'b0;
        if (nb == FL + 6) chk("in_ready_after_last_beat", beat.In_Ready, 0);
    endtask

    // Run the core handshake for one loaded frame and report Errors back.
    task automatic decode(input int e, input int rdelay, input bit vd_pre, input bit clr, input bit vd_after);
        int t;
        bit saw;
        if (rdelay > 0) begin
            saw = 1'b0;
            for (int i = 0; i < rdelay; i++) begin
                @(negedge Clock);
                saw |= Start;
            end
            chk("start_while_not_ready", saw, 0);
            Ready = 1'b1;
        end
        t = 0;
        while (!Start && t < 20) begin
            @(negedge Clock);
            t++;
        end
        chk("start_latency", t, 1);
        chk("in_ready_in_decode", beat.In_Ready, 0);
        if (vd_pre) begin
            repeat (3) @(negedge Clock);
            Valid_Data = 1'b0;
            @(negedge Clock);
        end
        repeat ($urandom_range(0, 3)) @(negedge Clock);
        Errors = 7'(e); Clear_Stats = clr; Valid_Data = 1'b1;
        model_capture(e, clr);
        @(negedge Clock);
        Clear_Stats = 1'b0; Errors = 7'($urandom); Valid_Data = vd_after;
        chk("in_ready_after_capture", beat.In_Ready, 1);
    endtask

    // Monitor: compare frame buffers on Start and statistics on Frame_Done.
    bit     start_q = 1'b0;
    frame_t mf;
    stats_t ms;
    always @(negedge Clock) begin
        if (!nReset) begin
            start_q = 1'b0;
        end else begin
            if (Start) begin
                n_start++;
                if (start_q) chk("start_single_cycle", 1, 0);
                if (exp_frames.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    mf = exp_frames.pop_front();
                    chk("b1_ideal", b1_ideal, mf.ideal);
                    chk("bua3", bua3, mf.ua3);
                    chk("bua2", bua2, mf.ua2);
                    chk("but1", but1, mf.ut1);
                    chk("bla2", bla2, mf.la2);
                    chk("blt1", blt1, mf.lt1);
                end
            end
            start_q = Start;
            if (Frame_Done) begin
                if (exp_stats.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    ms = exp_stats.pop_front();
                    chk("last_errors", Last_Errors, ms.last);
                    chk("total_errors", Total_Errors, ms.total);
                    chk("frame_count", Frame_Count, ms.count);
                end
            end
        end
    end

    initial begin
        int sat_err [5];
        sat_err = '{120, 120, 11, 9, 5};
        Clock = 1'b0;
        nReset = 1'b0;
        drive_idle();
        model_reset();
        apply_reset();

        // Index-pattern frame with Ready held high.
        Ready = 1'b1;
        send_beats(FL + 6, 0, 0);
        chk("bua3_5", bua3[5*N +: N], 4'd5);
        chk("bua2_106", bua2[106*N +: N], 4'h5);
        chk("but1_2", but1[2*N +: N], 4'd10);
        chk("blt1_0", blt1[0 +: N], 4'd11);
        chk("bla2_106", bla2[106*N +: N], 4'h8);
        chk("b1_ideal_3", b1_ideal[3], 1);
        decode(int'($urandom_range(0, 127)), 0, 1'b0, 1'b0, 1'b0);

        // Core not ready for 20 cycles after load.
        Ready = 1'b0;
        send_beats(FL + 6, 1, 2);
        decode(int'($urandom_range(0, 127)), 20, 1'b0, 1'b0, 1'b0);

        // Valid_Data already high on entry to decode is not a capture edge.
        Ready = 1'b1;
        Valid_Data = 1'b1;
        send_beats(FL + 6, 1, 0);
        decode(12, 0, 1'b1, 1'b0, 1'b0);
        chk("last_errors_12", Last_Errors, 12);

        // Stand-alone statistics clear.
        @(negedge Clock);
        Clear_Stats = 1'b1;
        m_total = 0; m_count = 0;
        @(negedge Clock);
        Clear_Stats = 1'b0;
        chk("clear_total", Total_Errors, 0);
        chk("clear_count", Frame_Count, 0);

        // Drive the total to 2^EW-5, then over the top.
        for (int i = 0; i < 5; i++) begin
            Ready = 1'b1;
            send_beats(FL + 6, 1, 2);
            decode(sat_err[i], 0, 1'b0, 1'b0, 1'b0);
            if (i == 3) chk("sat_total", Total_Errors, SAT);
        end

        // Clear coinciding with a capture.
        Ready = 1'b1;
        send_beats(FL + 6, 1, 0);
        decode(3, 0, 1'b0, 1'b1, 1'b0);
        chk("clear_capture_total", Total_Errors, 3);
        chk("clear_capture_count", Frame_Count, 1);

        // Random frames.
        for (int i = 0; i < 2; i++) begin
            Ready = 1'($urandom);
            send_beats(FL + 6, 1, 2);
            decode(int'($urandom_range(0, 127)), Ready ? 0 : int'($urandom_range(1, 5)),
                   1'b0, 1'b0, 1'b0);
        end

        // Reset part-way through a gapped frame, then a clean frame.
        send_beats(50, 1, 1);
        apply_reset();
        Ready = 1'b1;
        send_beats(FL + 6, 1, 0);
        decode(int'($urandom_range(0, 127)), 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge Clock);
        chk("frames_pending", exp_frames.size(), 0);
        chk("stats_pending", exp_stats.size(), 0);
        chk("start_count", n_start, n_frames_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
